// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - byte-wide stream interface carrying received lane payload
interface axi_stream_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aurora_rx_lane.sv
// rtl/aurora_rx_lane.sv - Aurora simplex receive lane: init FSM, error monitor and framer
module aurora_rx_lane #(
  parameter int ALIGN_COUNT  = 4,
  parameter int VERIFY_COUNT = 64,
  parameter int ERR_LIMIT    = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data_in,
  input  logic         ctrl_in,
  input  logic         code_err,
  axi_stream_if.master axi_stream,
  output logic         simplex_aligned,
  output logic         simplex_verified,
  output logic         simplex_reset,
  output logic         frame_err
);

  localparam logic [7:0] SYM_K    = 8'hBC;
  localparam logic [7:0] SYM_A    = 8'h7C;
  localparam logic [7:0] SYM_R    = 8'h1C;
  localparam logic [7:0] SYM_CC   = 8'hF7;
  localparam logic [7:0] SYM_SCP1 = 8'h5C;
  localparam logic [7:0] SYM_SCP2 = 8'hFB;
  localparam logic [7:0] SYM_ECP1 = 8'hFD;
  localparam logic [7:0] SYM_ECP2 = 8'hFE;

  // Counters run 0..COUNT-1; the transition fires on the symbol that would reach COUNT.
  localparam int ACW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam int VCW = (VERIFY_COUNT > 1) ? $clog2(VERIFY_COUNT) : 1;
  localparam logic [ACW-1:0] ALIGN_LAST  = ACW'(ALIGN_COUNT - 1);
  localparam logic [VCW-1:0] VERIFY_LAST = VCW'(VERIFY_COUNT - 1);
  localparam logic [7:0]     ERR_LAST    = 8'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {L_RESET, L_ALIGN, L_VERIFY, L_READY} lane_state_t;
  typedef enum logic [1:0] {F_IDLE, F_SCP1, F_IN_FRAME, F_ECP1} frm_state_t;

  lane_state_t    lane_q, lane_d;
  frm_state_t     frm_q, frm_d;
  logic           scp_in_frame_q, scp_in_frame_d;
  logic [ACW-1:0] align_cnt_q, align_cnt_d;
  logic [VCW-1:0] verify_cnt_q, verify_cnt_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_vld_q, hold_vld_d;
  logic [7:0]     tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic           tlast_q, tlast_d;
  logic           aligned_q, aligned_d;
  logic           verified_q, verified_d;
  logic           sreset_q, sreset_d;
  logic           ferr_q, ferr_d;
  logic           unused_tready;

  logic is_k, is_a, is_r, is_cc, is_scp1, is_scp2, is_ecp1, is_ecp2;
  assign is_k    = ctrl_in && (data_in == SYM_K);
  assign is_a    = ctrl_in && (data_in == SYM_A);
  assign is_r    = ctrl_in && (data_in == SYM_R);
  assign is_cc   = ctrl_in && (data_in == SYM_CC);
  assign is_scp1 = ctrl_in && (data_in == SYM_SCP1);
  assign is_scp2 = ctrl_in && (data_in == SYM_SCP2);
  assign is_ecp1 = ctrl_in && (data_in == SYM_ECP1);
  assign is_ecp2 = ctrl_in && (data_in == SYM_ECP2);

  assign axi_stream.tdata  = tdata_q;
  assign axi_stream.tvalid = tvalid_q;
  assign axi_stream.tlast  = tlast_q;
  assign unused_tready     = axi_stream.tready;
  assign simplex_aligned   = aligned_q;
  assign simplex_verified  = verified_q;
  assign simplex_reset     = sreset_q;
  assign frame_err         = ferr_q;

  // Next-state logic for the init FSM, error monitor and framer.
  always_comb begin
    lane_d         = lane_q;
    frm_d          = frm_q;
    scp_in_frame_d = scp_in_frame_q;
    align_cnt_d    = align_cnt_q;
    verify_cnt_d   = verify_cnt_q;
    err_cnt_d      = err_cnt_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    tdata_d        = tdata_q;
    tvalid_d       = 1'b0;
    tlast_d        = 1'b0;
    aligned_d      = aligned_q;
    verified_d     = verified_q;
    sreset_d       = 1'b0;
    ferr_d         = 1'b0;

    case (lane_q)
      L_RESET: begin
        lane_d      = L_ALIGN;
        align_cnt_d = '0;
        err_cnt_d   = '0;
      end
      L_ALIGN: begin
        if (is_k && !code_err) begin
          if (align_cnt_q == ALIGN_LAST) begin
            lane_d       = L_VERIFY;
            aligned_d    = 1'b1;
            verify_cnt_d = '0;
          end else begin
            align_cnt_d = align_cnt_q + 1'b1;
          end
        end else begin
          align_cnt_d = '0;
        end
      end
      L_VERIFY: begin
        // Errored symbols are left to the error monitor and neither count nor clear.
        if (!code_err) begin
          if (is_a) begin
            if (verify_cnt_q == VERIFY_LAST) begin
              lane_d     = L_READY;
              verified_d = 1'b1;
            end else begin
              verify_cnt_d = verify_cnt_q + 1'b1;
            end
          end else if (!(is_k || is_r || is_cc)) begin
            verify_cnt_d = '0;
          end
        end
      end
      L_READY: begin
        if (!code_err) begin
          case (frm_q)
            F_IDLE: begin
              if (is_scp1) begin
                frm_d          = F_SCP1;
                scp_in_frame_d = 1'b0;
              end else if (!ctrl_in || is_ecp1) begin
                ferr_d = 1'b1;
              end
            end
            F_SCP1: begin
              if (is_scp2) begin
                frm_d = F_IN_FRAME;
                if (scp_in_frame_q) begin
                  // A new SCP closes the open frame early.
                  ferr_d     = 1'b1;
                  tvalid_d   = hold_vld_q;
                  tlast_d    = 1'b1;
                  tdata_d    = hold_q;
                  hold_vld_d = 1'b0;
                end
              end else begin
                ferr_d = 1'b1;
                frm_d  = scp_in_frame_q ? F_IN_FRAME : F_IDLE;
              end
            end
            F_IN_FRAME: begin
              if (!ctrl_in) begin
                tvalid_d   = hold_vld_q;
                tdata_d    = hold_q;
                hold_d     = data_in;
                hold_vld_d = 1'b1;
              end else if (is_ecp1) begin
                frm_d = F_ECP1;
              end else if (is_scp1) begin
                frm_d          = F_SCP1;
                scp_in_frame_d = 1'b1;
              end
            end
            F_ECP1: begin
              if (is_ecp2) begin
                frm_d      = F_IDLE;
                tvalid_d   = hold_vld_q;
                tlast_d    = 1'b1;
                tdata_d    = hold_q;
                hold_vld_d = 1'b0;
              end else begin
                ferr_d = 1'b1;
                frm_d  = F_IN_FRAME;
              end
            end
          endcase
        end
      end
    endcase

    // Error monitor: overrides everything above when the limit trips.
    if ((lane_q == L_VERIFY || lane_q == L_READY) && code_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (err_cnt_q >= ERR_LAST) begin
        lane_d     = L_RESET;
        aligned_d  = 1'b0;
        verified_d = 1'b0;
        sreset_d   = 1'b1;
        ferr_d     = (frm_q == F_IN_FRAME) || (frm_q == F_ECP1) ||
                     ((frm_q == F_SCP1) && scp_in_frame_q);
        frm_d      = F_IDLE;
        hold_vld_d = 1'b0;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q         <= L_RESET;
      frm_q          <= F_IDLE;
      scp_in_frame_q <= 1'b0;
      align_cnt_q    <= '0;
      verify_cnt_q   <= '0;
      err_cnt_q      <= '0;
      hold_q         <= 8'h00;
      hold_vld_q     <= 1'b0;
      tdata_q        <= 8'h00;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      aligned_q      <= 1'b0;
      verified_q     <= 1'b0;
      sreset_q       <= 1'b0;
      ferr_q         <= 1'b0;
    end else begin
      lane_q         <= lane_d;
      frm_q          <= frm_d;
      scp_in_frame_q <= scp_in_frame_d;
      align_cnt_q    <= align_cnt_d;
      verify_cnt_q   <= verify_cnt_d;
      err_cnt_q      <= err_cnt_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      aligned_q      <= aligned_d;
      verified_q     <= verified_d;
      sreset_q       <= sreset_d;
      ferr_q         <= ferr_d;
    end
  end

endmodule

// File: tb/tb_aurora_rx_lane.sv
// tb/tb_aurora_rx_lane.sv - self-checking bench for aurora_rx_lane
module tb_aurora_rx_lane;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       ctrl_in;
  logic       code_err;
  logic       simplex_aligned;
  logic       simplex_verified;
  logic       simplex_reset;
  logic       frame_err;

  axi_stream_if axis ();
  assign axis.tready = 1'b1;

  aurora_rx_lane dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .ctrl_in          (ctrl_in),
    .code_err         (code_err),
    .axi_stream       (axis),
    .simplex_aligned  (simplex_aligned),
    .simplex_verified (simplex_verified),
    .simplex_reset    (simplex_reset),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] fillers[4] = '{8'hBC, 8'h1C, 8'h7C, 8'hF7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One symbol per cycle; outputs sampled 1 time unit after the edge that consumed it.
  task automatic send(input logic c, input logic [7:0] d, input logic e);
    ctrl_in  = c;
    data_in  = d;
    code_err = e;
    @(posedge clk);
    #1;
    if (axis.tvalid) obs_q.push_back({axis.tlast, axis.tdata});
    if (frame_err) fe_cnt++;
  endtask

  task automatic sk(input logic [7:0] d); send(1'b1, d, 1'b0); endtask
  task automatic sd(input logic [7:0] d); send(1'b0, d, 1'b0); endtask
  task automatic scp(); sk(8'h5C); sk(8'hFB); endtask
  task automatic ecp(); sk(8'hFD); sk(8'hFE); endtask
  task automatic filler(); sk(fillers[$urandom_range(3)]); endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    data_in  = 8'h00;
    ctrl_in  = 1'b0;
    code_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid",   32'(axis.tvalid),      32'd0);
    check("rst_tlast",    32'(axis.tlast),       32'd0);
    check("rst_tdata",    32'(axis.tdata),       32'd0);
    check("rst_aligned",  32'(simplex_aligned),  32'd0);
    check("rst_verified", 32'(simplex_verified), 32'd0);
    check("rst_sreset",   32'(simplex_reset),    32'd0);
    check("rst_ferr",     32'(frame_err),        32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    sd(8'h00);                      // RESET -> ALIGN

    // A frame before READY must not reach the stream or flag errors.
    scp(); sd(8'h99); ecp();

    // Broken comma run, then a full one.
    repeat (3) sk(8'hBC);
    sk(8'h1C);
    check("align_after_break", 32'(simplex_aligned), 32'd0);
    repeat (3) sk(8'hBC);
    check("align_3of4", 32'(simplex_aligned), 32'd0);
    sk(8'hBC);
    check("align_4of4", 32'(simplex_aligned), 32'd1);
    check("verified_early", 32'(simplex_verified), 32'd0);

    // 64 /A/ with tolerated /K/ /R/ /CC/ sprinkled in.
    for (int i = 0; i < 63; i++) begin
      if ($urandom_range(3) == 0) sk(fillers[$urandom_range(1) == 0 ? 0 : 1]);
      if ($urandom_range(5) == 0) sk(8'hF7);
      sk(8'h7C);
    end
    check("verify_63", 32'(simplex_verified), 32'd0);
    sk(8'h7C);
    check("verify_64", 32'(simplex_verified), 32'd1);
    check("pre_ready_beats", 32'(obs_q.size()), 32'd0);
    check("pre_ready_ferr", 32'(fe_cnt), 32'd0);
    obs_q.delete();
    fe_cnt = 0;

    // Basic frame with latency checks.
    scp();
    sd(8'h11);
    check("lat_11_none", 32'(axis.tvalid), 32'd0);
    sk(8'h1C);
    check("lat_r_none", 32'(axis.tvalid), 32'd0);
    sd(8'h22);
    check("lat_22_beat", 32'({axis.tvalid, axis.tlast, axis.tdata}), 32'h211);
    sd(8'h33);
    ecp();
    check("ecp_last_beat", 32'({axis.tvalid, axis.tlast, axis.tdata}), 32'h333);
    exp_q = '{9'h011, 9'h022, 9'h133};
    compare_beats("frame_basic");
    check("frame_basic_ferr", 32'(fe_cnt), 32'd0);

    // Empty frame, then stray data in IDLE.
    scp(); ecp();
    check("empty_beats", 32'(obs_q.size()), 32'd0);
    check("empty_ferr", 32'(fe_cnt), 32'd0);
    sd(8'h55);
    check("idle_data_ferr", 32'(frame_err), 32'd1);
    check("idle_data_tvalid", 32'(axis.tvalid), 32'd0);
    sk(8'hBC);
    check("idle_data_ferr_once", 32'(frame_err), 32'd0);
    check("idle_data_beats", 32'(obs_q.size()), 32'd0);
    fe_cnt = 0;

    // SCP inside a frame closes it early.
    scp(); sd(8'hAA); scp();
    check("rescp_ferr", 32'(frame_err), 32'd1);
    check("rescp_beat", 32'({axis.tvalid, axis.tlast, axis.tdata}), 32'h3AA);
    sd(8'hBB); ecp();
    exp_q = '{9'h1AA, 9'h1BB};
    compare_beats("rescp");
    check("rescp_ferr_total", 32'(fe_cnt), 32'd1);
    fe_cnt = 0;

    // Wrong second symbols of SCP and ECP.
    sk(8'h5C); sk(8'hBC);
    check("bad_scp_ferr", 32'(frame_err), 32'd1);
    sd(8'h66);
    check("bad_scp_back_idle", 32'(frame_err), 32'd1);
    scp(); sd(8'h10); sk(8'hFD); sk(8'hBC);
    check("bad_ecp_ferr", 32'(frame_err), 32'd1);
    sd(8'h20); ecp();
    exp_q = '{9'h010, 9'h120};
    compare_beats("bad_ecp");
    check("bad_seq_ferr_total", 32'(fe_cnt), 32'd3);
    fe_cnt = 0;

    // Random frames: expected beats are just the payload, last byte flagged.
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(6);
      repeat ($urandom_range(2)) filler();
      scp();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        repeat ($urandom_range(2)) filler();
        sd(b);
        exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, b});
      end
      repeat ($urandom_range(1)) filler();
      ecp();
    end
    compare_beats("random");
    check("random_ferr", 32'(fe_cnt), 32'd0);
    fe_cnt = 0;

    // Error limit trips while a byte is held.
    scp(); sd(8'h77);
    repeat (14) send(1'b1, 8'hBC, 1'b1);
    check("err14_sreset", 32'(simplex_reset), 32'd0);
    check("err14_verified", 32'(simplex_verified), 32'd1);
    send(1'b1, 8'hBC, 1'b1);
    check("err15_sreset", 32'(simplex_reset), 32'd1);
    check("err15_aligned", 32'(simplex_aligned), 32'd0);
    check("err15_verified", 32'(simplex_verified), 32'd0);
    check("err15_ferr", 32'(frame_err), 32'd1);
    check("err15_tvalid", 32'(axis.tvalid), 32'd0);
    sd(8'h00);
    check("sreset_one_cycle", 32'(simplex_reset), 32'd0);
    repeat (3) sk(8'hBC);
    check("realign_3", 32'(simplex_aligned), 32'd0);
    sk(8'hBC);
    check("realign_4", 32'(simplex_aligned), 32'd1);
    check("held_discarded", 32'(obs_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
